tlm_result_collector: RTL and testbench

- Receive-side counterpart of the TLM stimulus path: samples the DUT result stream (`res_o` of the bfm) one item per accepted cycle.
- Packs items into NUM-item batches in a ping-pong (two-bank) buffer.
- Presents each completed batch as one packed payload, with a valid/ready handshake, to the DPI-C export side for software-side checking.
- Sits in the testbench wrapper, beside the stimulus transmitter, on the same clock.

---
 rtl/tlm_pkg.sv | 17 +
 rtl/tlm_batch_bank.sv | 67 ++++++
 rtl/tlm_result_collector.sv | 121 ++++++++++++
 tb/tb_tlm_result_collector.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlm_pkg.sv
// Shared types and defaults for the TLM result collector.
// Latency/backpressure: n/a (types only).
package tlm_pkg;
    localparam int TLM_NUM_DEFAULT        = 1000;
    localparam int TLM_ITEM_WIDTH_DEFAULT = 8;

    typedef logic [$clog2(TLM_NUM_DEFAULT+1)-1:0] len_t;

    typedef enum logic {
        BANK_EMPTY = 1'b0,
        BANK_FULL  = 1'b1
    } bank_state_e;

    function automatic int len_width(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/tlm_batch_bank.sv
// One batch bank: NUM-slot item store with fill count, closed length and full flag.
// Latency: write/close/free take effect on the next clock edge.
// Backpressure: writes are ignored while FULL; the parent gates them with its ready.
module tlm_batch_bank
    import tlm_pkg::*;
#(
    parameter int NUM        = TLM_NUM_DEFAULT,
    parameter int ITEM_WIDTH = TLM_ITEM_WIDTH_DEFAULT,
    parameter int LW         = len_width(TLM_NUM_DEFAULT)
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      wr_en_i,
    input  logic [ITEM_WIDTH-1:0]     wr_dat_i,
    input  logic                      close_i,
    input  logic                      free_i,
    output logic [NUM*ITEM_WIDTH-1:0] data_o,
    output logic [LW-1:0]             count_o,
    output logic [LW-1:0]             len_o,
    output logic                      full_o
);
    localparam logic [LW-1:0] LAST_SLOT = LW'(NUM - 1);
    localparam logic [LW-1:0] FULL_LEN  = LW'(NUM);

    bank_state_e               state_q;
    logic [NUM*ITEM_WIDTH-1:0] data_q;
    logic [LW-1:0]             count_q;
    logic [LW-1:0]             len_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= BANK_EMPTY;
            data_q  <= '0;
            count_q <= '0;
            len_q   <= '0;
        end else begin
            if (wr_en_i && state_q == BANK_EMPTY) begin
                for (int k = 0; k < NUM; k++) begin
                    if (count_q == LW'(k)) begin
                        data_q[k*ITEM_WIDTH +: ITEM_WIDTH] <= wr_dat_i;
                    end
                end
                if (count_q == LAST_SLOT) begin
                    state_q <= BANK_FULL;
                    len_q   <= FULL_LEN;
                    count_q <= '0;
                end else begin
                    count_q <= count_q + 1'b1;
                end
            end else if (close_i && state_q == BANK_EMPTY && count_q != '0) begin
                // Early close of a partial batch; slots past count keep old data.
                state_q <= BANK_FULL;
                len_q   <= count_q;
                count_q <= '0;
            end
            if (free_i && state_q == BANK_FULL) begin
                state_q <= BANK_EMPTY;
                len_q   <= '0;
            end
        end
    end

    assign data_o  = data_q;
    assign count_o = count_q;
    assign len_o   = len_q;
    assign full_o  = (state_q == BANK_FULL);
endmodule

// File: rtl/tlm_result_collector.sv
// Packs result items into NUM-item batches in two ping-pong banks; TLM_COLLECT_TIMEOUT_EN adds idle flush.
// Latency: batch_valid_o rises the cycle after the closing item is accepted.
// Backpressure: res_ready_o drops only while the write bank is full (both banks pending).
module tlm_result_collector
    import tlm_pkg::*;
#(
    parameter int NUM        = TLM_NUM_DEFAULT,
    parameter int ITEM_WIDTH = TLM_ITEM_WIDTH_DEFAULT,
    parameter int TIMEOUT    = 64
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [ITEM_WIDTH-1:0]         res_i,
    input  logic                          res_valid_i,
    output logic                          res_ready_o,
    output logic [NUM*ITEM_WIDTH-1:0]     batch_data_o,
    output logic [$clog2(NUM+1)-1:0]      batch_len_o,
    output logic                          batch_valid_o,
    input  logic                          batch_ready_i,
    output logic [31:0]                   batch_cnt_o
);
    localparam int LW = len_width(NUM);

    if (NUM < 2 || TIMEOUT < 1) begin : g_param_check
        $error("tlm_result_collector: NUM must be >= 2 and TIMEOUT >= 1");
    end

    logic                      wr_ptr_q, wr_ptr_d;
    logic                      rd_ptr_q, rd_ptr_d;
    logic [31:0]               batch_cnt_q, batch_cnt_d;
    logic [1:0]                bank_wr, bank_close, bank_free, bank_full;
    logic [NUM*ITEM_WIDTH-1:0] bank_data [2];
    logic [LW-1:0]             bank_count [2];
    logic [LW-1:0]             bank_len [2];
    logic [LW-1:0]             wr_count;
    logic                      accept, handoff, close_last, timeout_fire;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign bank_wr[b]    = accept && (int'(wr_ptr_q) == b);
        assign bank_close[b] = timeout_fire && (int'(wr_ptr_q) == b);
        assign bank_free[b]  = handoff && (int'(rd_ptr_q) == b);

        tlm_batch_bank #(
            .NUM        (NUM),
            .ITEM_WIDTH (ITEM_WIDTH),
            .LW         (LW)
        ) u_bank (
            .clk_i    (clk_i),
            .reset_i  (reset_i),
            .wr_en_i  (bank_wr[b]),
            .wr_dat_i (res_i),
            .close_i  (bank_close[b]),
            .free_i   (bank_free[b]),
            .data_o   (bank_data[b]),
            .count_o  (bank_count[b]),
            .len_o    (bank_len[b]),
            .full_o   (bank_full[b])
        );
    end

    // Ready depends only on bank state, never on batch_ready_i.
    assign res_ready_o   = !bank_full[wr_ptr_q];
    assign accept        = res_valid_i && res_ready_o;
    assign batch_valid_o = bank_full[rd_ptr_q];
    assign handoff       = batch_valid_o && batch_ready_i;
    assign batch_data_o  = bank_data[rd_ptr_q];
    assign batch_len_o   = bank_len[rd_ptr_q];
    assign batch_cnt_o   = batch_cnt_q;
    assign wr_count      = bank_count[wr_ptr_q];
    assign close_last    = accept && (wr_count == LW'(NUM - 1));

`ifdef TLM_COLLECT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] idle_q, idle_d;

    // An accept always clears the counter, so it beats a coincident timeout.
    always_comb begin
        idle_d       = idle_q;
        timeout_fire = 1'b0;
        if (accept) begin
            idle_d = '0;
        end else if (wr_count != '0) begin
            if (idle_q == TW'(TIMEOUT - 1)) begin
                timeout_fire = 1'b1;
                idle_d       = '0;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    assign timeout_fire = 1'b0;
`endif

    always_comb begin
        wr_ptr_d    = wr_ptr_q ^ (close_last | timeout_fire);
        rd_ptr_d    = rd_ptr_q ^ handoff;
        batch_cnt_d = batch_cnt_q + {31'd0, handoff};
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            batch_cnt_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            batch_cnt_q <= batch_cnt_d;
        end
    end
endmodule

// File: tb/tb_tlm_result_collector.sv
// Bench for tlm_result_collector: vector table, directed corner sequences and a random run
// checked against a queue-based batch model.
module tb_tlm_result_collector;
    localparam int NUM = 4;
    localparam int W   = 8;
    localparam int TO  = 8;
    localparam int LW  = $clog2(NUM + 1);
    localparam int DW  = NUM * W;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  res;
    logic          res_valid, res_ready;
    logic [DW-1:0] batch_data;
    logic [LW-1:0] batch_len;
    logic          batch_valid, batch_ready;
    logic [31:0]   batch_cnt;

    always #5 clk = ~clk;

    tlm_result_collector #(.NUM(NUM), .ITEM_WIDTH(W), .TIMEOUT(TO)) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .res_i         (res),
        .res_valid_i   (res_valid),
        .res_ready_o   (res_ready),
        .batch_data_o  (batch_data),
        .batch_len_o   (batch_len),
        .batch_valid_o (batch_valid),
        .batch_ready_i (batch_ready),
        .batch_cnt_o   (batch_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: queue of closed batches awaiting handoff, plus the batch being filled.
    logic [DW-1:0] m_dat[$];
    int            m_len[$];
    logic [W-1:0]  m_cur[$];
    int            m_cnt;
    int            m_idle;
    logic [DW-1:0] got[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mask(input int len);
        logic [DW-1:0] m;
        m = '0;
        for (int k = 0; k < len * W && k < DW; k++) m[k] = 1'b1;
        return m;
    endfunction

    task automatic model_reset();
        m_dat.delete();
        m_len.delete();
        m_cur.delete();
        got.delete();
        m_cnt  = 0;
        m_idle = 0;
    endtask

    task automatic close_cur();
        logic [DW-1:0] p;
        p = '0;
        foreach (m_cur[k]) p[k*W +: W] = m_cur[k];
        m_dat.push_back(p);
        m_len.push_back(m_cur.size());
        m_cur.delete();
    endtask

    task automatic check_model(input string tag);
        chk({tag, " ready"}, res_ready, m_dat.size() < 2);
        chk({tag, " valid"}, batch_valid, m_dat.size() > 0);
        chk({tag, " cnt"}, batch_cnt, m_cnt);
        if (m_dat.size() > 0) begin
            chk({tag, " len"}, batch_len, m_len[0]);
            chk({tag, " data"}, batch_data & mask(m_len[0]), m_dat[0]);
        end else begin
            chk({tag, " len idle"}, batch_len, 0);
        end
    endtask

    task automatic cycle(input logic v, input logic [W-1:0] d, input logic br,
                         input string tag, output logic acc);
        logic hand;
        res_valid   = v;
        res         = d;
        batch_ready = br;
        acc  = v && (m_dat.size() < 2);
        hand = (m_dat.size() > 0) && br;
        if (batch_valid && br) got.push_back(batch_data);
        @(posedge clk);
        if (hand) begin
            void'(m_dat.pop_front());
            void'(m_len.pop_front());
            m_cnt++;
        end
        if (acc) begin
            m_cur.push_back(d);
            m_idle = 0;
            if (m_cur.size() == NUM) close_cur();
        end
`ifdef TLM_COLLECT_TIMEOUT_EN
        else if (m_cur.size() > 0) begin
            m_idle++;
            if (m_idle == TO) begin
                close_cur();
                m_idle = 0;
            end
        end
`endif
        @(negedge clk);
        check_model(tag);
    endtask

    typedef struct {
        logic          v;
        logic [W-1:0]  d;
        logic          br;
        logic          e_rdy;
        logic          e_vld;
        logic [DW-1:0] e_dat;
        logic [LW-1:0] e_len;
        logic [31:0]   e_cnt;
    } vec_t;

    vec_t          tbl[6];
    logic          acc;
    int            idx;
    logic [DW-1:0] cap_dat;
    logic [LW-1:0] cap_len;
    logic [31:0]   cap_cnt;
    logic [DW-1:0] exp2[3];
    int            rise;
    logic          seen;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 32'h0, 3'd0, 32'd0};
        tbl[1] = '{1'b1, 8'h02, 1'b1, 1'b1, 1'b0, 32'h0, 3'd0, 32'd0};
        tbl[2] = '{1'b1, 8'h03, 1'b1, 1'b1, 1'b0, 32'h0, 3'd0, 32'd0};
        tbl[3] = '{1'b1, 8'h04, 1'b1, 1'b1, 1'b1, 32'h04030201, 3'd4, 32'd0};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0, 3'd0, 32'd1};
        tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0, 3'd0, 32'd1};
        exp2[0] = 32'h13121110;
        exp2[1] = 32'h17161514;
        exp2[2] = 32'h1B1A1918;

        reset = 1'b1; res_valid = 1'b0; res = '0; batch_ready = 1'b0;
        model_reset();
        #12;
        chk("reset ready", res_ready, 1);
        chk("reset valid", batch_valid, 0);
        chk("reset len", batch_len, 0);
        chk("reset data", batch_data, 0);
        chk("reset cnt", batch_cnt, 0);
        @(negedge clk);
        reset = 1'b0;

        // Single full batch through a ready consumer.
        for (int i = 0; i < 6; i++) begin
            cycle(tbl[i].v, tbl[i].d, tbl[i].br, "t1", acc);
            chk("t1 tbl ready", res_ready, tbl[i].e_rdy);
            chk("t1 tbl valid", batch_valid, tbl[i].e_vld);
            chk("t1 tbl len", batch_len, tbl[i].e_len);
            chk("t1 tbl cnt", batch_cnt, tbl[i].e_cnt);
            if (tbl[i].e_vld) chk("t1 tbl data", batch_data, tbl[i].e_dat);
        end

        // Both banks fill while the consumer stalls, then drain in order.
        idx = 8'h10;
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, W'(idx), 1'b0, "t2 stall", acc);
            if (acc) idx++;
        end
        chk("t2 accepted before stall", idx, 8'h18);
        chk("t2 ready low when both full", res_ready, 0);
        got.delete();
        for (int i = 0; i < 12; i++) begin
            cycle(idx <= 8'h1B, W'(idx), 1'b1, "t2 drain", acc);
            if (acc) idx++;
        end
        chk("t2 all items accepted", idx, 8'h1C);
        chk("t2 batch count", got.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < got.size()) chk("t2 batch order", got[i], exp2[i]);
        end

        // Pending batch held stable under backpressure.
        for (int i = 0; i < 4; i++) cycle(1'b1, W'(8'h21 + i), 1'b0, "t3 fill", acc);
        cap_dat = batch_data;
        cap_len = batch_len;
        cap_cnt = batch_cnt;
        chk("t3 pending data", cap_dat, 32'h24232221);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, '0, 1'b0, "t3 hold", acc);
            chk("t3 data stable", batch_data, cap_dat);
            chk("t3 len stable", batch_len, cap_len);
            chk("t3 cnt stable", batch_cnt, cap_cnt);
        end
        cycle(1'b0, '0, 1'b1, "t3 take", acc);
        chk("t3 cnt after take", batch_cnt, cap_cnt + 1);

        // Asynchronous reset with one full bank and a partial one.
        for (int i = 0; i < 6; i++) cycle(1'b1, W'(8'h31 + i), 1'b0, "t4 pre", acc);
        #2;
        reset = 1'b1;
        #1;
        chk("t4 async ready", res_ready, 1);
        chk("t4 async valid", batch_valid, 0);
        chk("t4 async len", batch_len, 0);
        chk("t4 async data", batch_data, 0);
        chk("t4 async cnt", batch_cnt, 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, W'(8'h41 + i), 1'b1, "t4 post", acc);
        cycle(1'b0, '0, 1'b1, "t4 post", acc);
        chk("t4 fresh cnt", batch_cnt, 1);
        chk("t4 fresh batch seen", got.size(), 1);
        if (got.size() > 0) chk("t4 fresh batch data", got[0], 32'h44434241);

        // Partial batch followed by a long idle period.
        cycle(1'b1, 8'hAA, 1'b0, "t5", acc);
        cycle(1'b1, 8'hBB, 1'b0, "t5", acc);
`ifdef TLM_COLLECT_TIMEOUT_EN
        rise = 0;
        for (int i = 1; i <= 20; i++) begin
            cycle(1'b0, '0, 1'b0, "t5 idle", acc);
            if (batch_valid && rise == 0) begin
                rise = i;
                chk("t5 timeout len", batch_len, 2);
                chk("t5 timeout data", batch_data[15:0], 16'hBBAA);
            end
        end
        chk("t5 timeout idle cycles", rise, TO);
        cycle(1'b0, '0, 1'b1, "t5 take", acc);
`else
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            cycle(1'b0, '0, 1'b0, "t5 idle", acc);
            if (batch_valid) seen = 1'b1;
        end
        chk("t5 no partial flush", seen, 0);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, W'($urandom), 1'($urandom_range(0, 1)), "rand", acc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
